// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Central sequencing controller for the 5-stage RV32 pipeline. It decides, each
// cycle, which pipeline registers load, which load a bubble, and whether the PC
// advances. Three hazard sources are handled:
//   - load-use (load in EX feeding a source operand of the instruction in ID)
//   - taken branch / jump redirect resolved in EX
//   - instruction / data memory busy-wait
//
// Parameters
//   REG_ADDR_W       register address width
//   LOAD_USE_STALLS  bubbles per load-use hazard, legal 1..3
//                    (1 with MEM->EX forwarding, 2 without)
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   ID_RS1, ID_RS2             source registers of the ID instruction
//   ID_USE_RS1, ID_USE_RS2     ID instruction really reads RS1 / RS2
//   EX_RD                      destination register of the EX instruction
//   EX_MEM_READ                load type in EX, nonzero = load
//   BRANCH_TAKEN               EX resolved a taken branch / jump
//   IMEM_BUSY_WAIT             instruction memory not ready
//   DMEM_BUSY_WAIT             data memory not ready
//   PC_WRITE                   PC update enable
//   IF_ID_EN .. MEM_WB_EN      stage register load enables
//   IF_ID_FLUSH, ID_EX_FLUSH   stage loads a bubble instead of its input
//   HAZARD_STATE               0 = RUN, 1 = LU_STALL
//
// Optional build macro HAZARD_PERF_CNT_EN adds three free-running 32-bit
// performance counters (LU_STALL_CNT, FLUSH_CNT, MEM_STALL_CNT). Without the
// macro those ports and their logic do not exist.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USE_RS1,
  input  logic                  ID_USE_RS2,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic [2:0]            EX_MEM_READ,
  input  logic                  BRANCH_TAKEN,
  input  logic                  IMEM_BUSY_WAIT,
  input  logic                  DMEM_BUSY_WAIT,
  output logic                  PC_WRITE,
  output logic                  IF_ID_EN,
  output logic                  ID_EX_EN,
  output logic                  EX_MEM_EN,
  output logic                  MEM_WB_EN,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_FLUSH,
  output logic                  HAZARD_STATE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           LU_STALL_CNT,
  output logic [31:0]           FLUSH_CNT,
  output logic [31:0]           MEM_STALL_CNT
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  // Counter value loaded when the first bubble is issued: the first bubble is
  // produced from RUN, the rest are counted down in LU_STALL.
  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALLS - 1);

  state_t     state;
  logic [1:0] cnt;

  logic lu_hazard;
  logic case_freeze;
  logic case_redirect;
  logic case_stall_cont;
  logic case_stall_new;
  logic case_fetch;

  // x0 is never a real destination, so EX_RD == 0 cannot create a hazard.
  function automatic logic lu_hazard_f(
    input logic [2:0]            mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic                  use_rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use_rs2
  );
    return (mem_read != 3'd0) && (rd != '0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

  assign lu_hazard = lu_hazard_f(EX_MEM_READ, EX_RD, ID_RS1, ID_USE_RS1,
                                 ID_RS2, ID_USE_RS2);

  // One-hot priority decode: data-memory freeze beats redirect beats an
  // ongoing stall beats a new load-use stall beats a fetch bubble.
  assign case_freeze     = DMEM_BUSY_WAIT;
  assign case_redirect   = !DMEM_BUSY_WAIT && BRANCH_TAKEN;
  assign case_stall_cont = !DMEM_BUSY_WAIT && !BRANCH_TAKEN && (state == LU_STALL);
  assign case_stall_new  = !DMEM_BUSY_WAIT && !BRANCH_TAKEN && (state == RUN) &&
                           lu_hazard;
  assign case_fetch      = !DMEM_BUSY_WAIT && !BRANCH_TAKEN && (state == RUN) &&
                           !lu_hazard && IMEM_BUSY_WAIT;

  // Stage controls: combinational from registered state plus current inputs.
  always_comb begin
    PC_WRITE     = 1'b1;
    IF_ID_EN     = 1'b1;
    ID_EX_EN     = 1'b1;
    EX_MEM_EN    = 1'b1;
    MEM_WB_EN    = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    HAZARD_STATE = (state == LU_STALL);

    if (RESET) begin
      PC_WRITE     = 1'b0;
      IF_ID_EN     = 1'b0;
      ID_EX_EN     = 1'b0;
      EX_MEM_EN    = 1'b0;
      MEM_WB_EN    = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      HAZARD_STATE = 1'b0;
    end else if (case_freeze) begin
      PC_WRITE  = 1'b0;
      IF_ID_EN  = 1'b0;
      ID_EX_EN  = 1'b0;
      EX_MEM_EN = 1'b0;
      MEM_WB_EN = 1'b0;
    end else if (case_redirect) begin
      // PC loads the branch target; both younger instructions are squashed.
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (case_stall_cont || case_stall_new) begin
      // Hold PC and IF/ID, push a bubble into EX, let the load advance.
      PC_WRITE    = 1'b0;
      IF_ID_EN    = 1'b0;
      ID_EX_FLUSH = 1'b1;
    end else if (case_fetch) begin
      // Fetch not ready: keep the PC and feed a bubble into ID.
      PC_WRITE    = 1'b0;
      IF_ID_FLUSH = 1'b1;
    end
  end

  // Load-use FSM: state and remaining-bubble counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (case_freeze) begin
      state <= state;
      cnt   <= cnt;
    end else if (case_redirect) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (case_stall_cont) begin
      cnt <= cnt - 2'd1;
      if (cnt == 2'd1) begin
        state <= RUN;
      end
    end else if (case_stall_new) begin
      // With a single bubble the stall is fully served from RUN.
      if (LOAD_USE_STALLS > 1) begin
        state <= LU_STALL;
        cnt   <= STALL_RELOAD;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters wrap naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      LU_STALL_CNT  <= 32'd0;
      FLUSH_CNT     <= 32'd0;
      MEM_STALL_CNT <= 32'd0;
    end else begin
      if (case_stall_cont || case_stall_new) begin
        LU_STALL_CNT <= LU_STALL_CNT + 32'd1;
      end
      if (case_redirect) begin
        FLUSH_CNT <= FLUSH_CNT + 32'd1;
      end
      if (case_freeze) begin
        MEM_STALL_CNT <= MEM_STALL_CNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage RV32 pipeline.
- Detects load-use hazards (ID vs EX), taken-branch redirects resolved in EX, and instruction/data memory busy-wait.
- Drives per-stage enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- All pipeline registers take their stall/bubble controls from this block, not directly from the memories.

Parameters:
- REG_ADDR_W, 5, register address width.
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard. Legal range 1..3: 1 with MEM→EX forwarding, 2 without.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ID_RS1, ID_RS2  in  REG_ADDR_W  source registers of the instruction in ID.
- ID_USE_RS1, ID_USE_RS2  in  1  ID instruction actually reads RS1/RS2.
- EX_RD  in  REG_ADDR_W  destination register of the instruction in EX.
- EX_MEM_READ  in  3  load type in EX; nonzero means load.
- BRANCH_TAKEN  in  1  EX resolved a taken branch or jump this cycle.
- IMEM_BUSY_WAIT  in  1  instruction memory not ready.
- DMEM_BUSY_WAIT  in  1  data memory not ready.
- PC_WRITE  out  1  PC register update enable.
- IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1  stage register load enables.
- IF_ID_FLUSH, ID_EX_FLUSH  out  1  load a bubble (all controls 0) instead of the stage input.
- HAZARD_STATE  out  1  0 = RUN, 1 = LU_STALL.

Behaviour:
- FSM states: RUN, LU_STALL. Down-counter CNT of width 2, registered.
- Outputs are combinational from registered state plus current inputs. State and CNT update on CLK rising edge only.
- Reset (synchronous):
  - State = RUN, CNT = 0.
  - While RESET=1, all outputs are forced: PC_WRITE=0, all *_EN=0, IF_ID_FLUSH=1, ID_EX_FLUSH=1, HAZARD_STATE=0.
  - Reset mid-stall abandons the stall; the first cycle after reset is RUN.
- LU hazard term: EX_MEM_READ!=0 AND EX_RD!=0 AND ((ID_USE_RS1 AND ID_RS1==EX_RD) OR (ID_USE_RS2 AND ID_RS2==EX_RD)).
- Per-cycle priority (first match wins):
  1. DMEM_BUSY_WAIT=1 (freeze):
     - All enables 0, both flushes 0.
     - State and CNT hold.
  2. BRANCH_TAKEN=1 (redirect):
     - PC_WRITE=1, all *_EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1.
     - Next state RUN, CNT cleared.
     - Overrides a simultaneous LU hazard and IMEM busy; the PC still loads the target.
  3. State LU_STALL (continue stall):
     - PC_WRITE=0, IF_ID_EN=0, ID_EX_EN=1, ID_EX_FLUSH=1, EX_MEM_EN=1, MEM_WB_EN=1, IF_ID_FLUSH=0.
     - CNT decrements; when CNT==1 the next state is RUN.
  4. State RUN with LU hazard:
     - Same outputs as item 3; this is bubble #1.
     - If LOAD_USE_STALLS>1: next state LU_STALL, CNT = LOAD_USE_STALLS-1. Otherwise stay in RUN.
  5. IMEM_BUSY_WAIT=1 (fetch bubble):
     - PC_WRITE=0, IF_ID_EN=1, IF_ID_FLUSH=1, all later stages enabled, ID_EX_FLUSH=0.
  6. Otherwise: all enables 1, both flushes 0.
- Invariants:
  - The flush outputs are only meaningful when the matching enable is 1 (the stage loads a bubble).
  - No output ever asserts a flush together with enable=0, except during reset.
- Latency:
  - Hazard response is same-cycle (combinational).
  - A load-use hazard costs exactly LOAD_USE_STALLS cycles plus any DMEM freeze cycles.
- EX_RD==0 never causes a stall (x0 is not a real destination).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs LU_STALL_CNT, FLUSH_CNT, MEM_STALL_CNT (32 bits each).
  - Each counter increments on a cycle whose priority case is 3 or 4, case 2, or case 1 respectively.
  - Counters clear on RESET and wrap at 2^32-1 → 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use, LOAD_USE_STALLS=1: EX_MEM_READ=3'b010, EX_RD=5, ID_RS1=5, ID_USE_RS1=1 → one cycle with PC_WRITE=0, IF_ID_EN=0, ID_EX_FLUSH=1; next cycle (EX_MEM_READ=0) all enables 1; HAZARD_STATE stays 0.
- Load-use, LOAD_USE_STALLS=2: same stimulus → two consecutive stall cycles; HAZARD_STATE=1 in the second cycle only; third cycle normal.
- Branch while hazard: BRANCH_TAKEN=1, hazard condition true, IMEM_BUSY_WAIT=1 → PC_WRITE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, state RUN.
- DMEM freeze mid-stall (LOAD_USE_STALLS=3): DMEM_BUSY_WAIT=1 for 4 cycles during LU_STALL → all enables 0 and CNT held for 4 cycles; the stall then completes with its remaining count intact.
- Reset during LU_STALL: RESET=1 for 1 cycle → all enables 0 and both flushes 1 during reset; next cycle HAZARD_STATE=0 with no stall unless the hazard is re-presented.
- No false stall: EX_RD=0, EX_MEM_READ=3'b010, ID_RS1=0, ID_USE_RS1=1 → no stall. IMEM_BUSY_WAIT=1 alone → PC_WRITE=0, IF_ID_FLUSH=1, other stages enabled.
